// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants,
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Small synchronous FIFO with a combinational head read. Push while full
// and pop while empty are ignored, so callers may strobe freely.
module uart_tx_fifo_mem #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                    DEPTH   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; entries are only readable after a push, and
  // leaving the array out of the reset keeps it mappable to plain RAM.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: CPU writes land in a FIFO that an 8N1
// serializer drains at CLK_FREQ/BAUD cycles per bit, with polling status.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  input  logic       clr_ovf,
  output logic       tx_done,
  output logic       UART_TX
);

  localparam int               DIV      = CLK_FREQ / BAUD;
  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e         state;
  logic [CNT_W-1:0]    baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic                tx_line;
  logic                tx_done_r;
  logic                ovf_r;
  logic                last_tick;
  logic                pop;
  logic                fifo_empty;
  logic [7:0]          fifo_data;
  logic [DEPTH_LOG2:0] fifo_count;

  uart_tx_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (8)
  ) u_mem (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (wr_en),
    .wr_data(wr_data),
    .pop    (pop),
    .rd_data(fifo_data),
    .full   (full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign last_tick = (baud_cnt == CNT_LAST);
  // A new frame is fetched either from idle or straight out of the stop bit.
  assign pop       = !fifo_empty && ((state == IDLE) || (state == STOP && last_tick));

  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign overflow  = ovf_r;
  assign tx_done   = tx_done_r;
  assign UART_TX   = tx_line;

  // NOTE: non-blocking assignments throughout, so every branch below sees
  // the pre-edge state and the registers update together.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_line   <= LINE_IDLE;
      tx_done_r <= 1'b0;
    end else begin
      // Registered one cycle ahead so the pulse covers the final stop cycle.
      tx_done_r <= (state == STOP) && (baud_cnt == CNT_PRE);
      baud_cnt  <= (state == IDLE || last_tick) ? '0 : baud_cnt + CNT_ONE;
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= fifo_data;
            state   <= START;
            tx_line <= ~LINE_IDLE;
          end else begin
            tx_line <= LINE_IDLE;
          end
        end
        START: begin
          if (last_tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_line <= shift[0];
          end
        end
        DATA: begin
          if (last_tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == BIT_LAST) begin
              state   <= STOP;
              tx_line <= LINE_IDLE;
            end else begin
              tx_line <= shift[1];
            end
          end
        end
        STOP: begin
          if (last_tick) begin
            if (pop) begin
              shift   <= fifo_data;
              state   <= START;
              tx_line <= ~LINE_IDLE;
            end else begin
              state   <= IDLE;
              tx_line <= LINE_IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A dropped write outranks a same-cycle clear so no drop goes unreported.
  always_ff @(posedge sysclk) begin
    if (!reset)              ovf_r <= 1'b0;
    else if (wr_en && full)  ovf_r <= 1'b1;
    else if (clr_ovf)        ovf_r <= 1'b0;
  end

endmodule
